// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI slave endpoint, LSB-first, one DATA_W-bit word per
// chip-select assertion.
//
// Bus timing:
// - MOSI is sampled on negedge SCLK.
// - MISO and all control/handshake state update on posedge SCLK.
//
// The shift register and bit counter live in the negedge domain. A transfer
// start is flagged in the posedge domain (start_q), so the first negedge of a
// transfer seeds the shift register from the word captured at the start edge.
//
// Optional build macro: SPI_SLAVE_TRISTATE_EN
// - Defined: MISO floats (1'bz) while CS_n is high.
// - Undefined: MISO is always the registered value.
module spi_slave_port #(
    parameter int DATA_W = 8
) (
    input  logic              SCLK,
    input  logic              reset,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] txData,
    input  logic              txLoad,
    output logic              txReady,
    output logic [DATA_W-1:0] rxData,
    output logic              rxValid,
    input  logic              rxAck,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // posedge-domain registers
    logic              miso_q,     miso_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q,  overrun_d;
    logic [DATA_W-1:0] hold_q,     hold_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] tx_word_q,  tx_word_d;
    logic              start_q,    start_d;

    // negedge-domain registers
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;

    // decoded events for the current posedge
    logic              start_s;
    logic              complete_s;
    logic              shift_out_s;
    logic [DATA_W-1:0] load_word_s;

    // State register: transfer FSM, posedge domain
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start on CS_n low, finish after DATA_W bits,
    // abort if CS_n rises mid-word, rearm only after CS_n deasserts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!CS_n) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    state_d = ST_DONE;
                end else if (CS_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (CS_n) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: which datapath action this posedge performs
    always_comb begin
        start_s     = 1'b0;
        complete_s  = 1'b0;
        shift_out_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_s = !CS_n;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    complete_s = 1'b1;
                end else begin
                    shift_out_s = 1'b1;
                end
            end
            ST_DONE: begin
                start_s = 1'b0;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // Posedge datapath next values: MISO, TX holding register, RX handshake
    always_comb begin
        // An empty holding register transmits all zeros
        if (tx_ready_q) begin
            load_word_s = '0;
        end else begin
            load_word_s = hold_q;
        end

        start_d   = start_s;
        tx_word_d = tx_word_q;
        miso_d    = miso_q;
        if (start_s) begin
            tx_word_d = load_word_s;
            miso_d    = load_word_s[0];
        end else if (shift_out_s) begin
            miso_d    = shreg_q[0];
        end else begin
            miso_d    = miso_q;
        end

        // The start edge frees the holding register, so a load on that same
        // edge is already accepted for the following transfer
        hold_d     = hold_q;
        tx_ready_d = tx_ready_q;
        if (start_s) begin
            tx_ready_d = 1'b1;
        end else begin
            tx_ready_d = tx_ready_q;
        end
        if (txLoad && (tx_ready_q || start_s)) begin
            hold_d     = txData;
            tx_ready_d = 1'b0;
        end else begin
            hold_d     = hold_q;
        end

        // Acknowledge clears; a completion on the same edge wins
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (rxAck) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        if (complete_s) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rxAck) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else begin
            rx_data_d  = rx_data_q;
        end
    end

    // Posedge datapath registers
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            hold_q     <= '0;
            tx_ready_q <= 1'b1;
            tx_word_q  <= '0;
            start_q    <= 1'b0;
        end else begin
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            hold_q     <= hold_d;
            tx_ready_q <= tx_ready_d;
            tx_word_q  <= tx_word_d;
            start_q    <= start_d;
        end
    end

    // Negedge shift next values: the first negedge of a transfer seeds from
    // the captured TX word; later ones shift while CS_n is low
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (start_q) begin
            if (!CS_n) begin
                shreg_d   = {MOSI, tx_word_q[DATA_W-1:1]};
                bit_cnt_d = CNT_ONE;
            end else begin
                shreg_d   = tx_word_q;
                bit_cnt_d = '0;
            end
        end else if ((state_q == ST_SHIFT) && !CS_n && (bit_cnt_q != CNT_FULL)) begin
            shreg_d   = {MOSI, shreg_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Negedge shift register and bit counter
    always_ff @(negedge SCLK or posedge reset) begin
        if (reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

`ifdef SPI_SLAVE_TRISTATE_EN
    assign MISO = CS_n ? 1'bz : miso_q;
`else
    assign MISO = miso_q;
`endif

    assign txReady = tx_ready_q;
    assign rxData  = rx_data_q;
    assign rxValid = rx_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/spi_slave_port.md
Name: spi_slave_port

Overview:
- SPI slave endpoint that sits directly downstream of the SPI master on the shared SCLK/MOSI/MISO bus. One instance sits behind each active-low chip-select line.
- Shifts in one DATA_W-bit word from MOSI, LSB first, while simultaneously shifting out a preloaded word on MISO.
- Presents each received word to local logic through a valid/ack handshake, with sticky overrun detection.
- Bus timing matches the master: master drives MOSI on posedge SCLK and samples MISO on negedge SCLK.

Parameters:
- DATA_W, 8, word width in bits; also the bits per transfer.

Ports:
- SCLK  input  1  serial clock; all logic is clocked on its edges
- reset  input  1  asynchronous, active-high reset
- CS_n  input  1  chip select from the master, active low
- MOSI  input  1  serial data from the master
- MISO  output  1  serial data to the master
- txData  input  DATA_W  word to transmit on the next transfer
- txLoad  input  1  load strobe for txData, sampled on posedge SCLK
- txReady  output  1  TX holding register is empty and can accept txLoad
- rxData  output  DATA_W  last completed received word
- rxValid  output  1  rxData holds an unconsumed word
- rxAck  input  1  consumer acknowledge, sampled on posedge SCLK
- overrun  output  1  sticky flag: a word completed while rxValid was still set
- busy  output  1  a transfer is in progress (state is not IDLE)

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is SCLK.
- Reset values: MISO=0, rxData=0, rxValid=0, overrun=0, txReady=1, busy=0. Internally: state=IDLE, bitCnt=0, shift register=0, holding register empty.
- TX holding register (posedge SCLK):
  - If txLoad=1 and txReady=1: capture txData and set txReady=0.
  - If txLoad=1 and txReady=0: ignored; the held value is kept.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT, on the first posedge with CS_n=0:
  - Shift register is loaded with the held word, or with all zeros if the holding register is empty.
  - MISO is driven with bit0 of that loaded value on the same edge.
  - Holding register is released (txReady=1). A txLoad on this same edge is accepted for the next transfer.
  - bitCnt=0.
- SHIFT, negedge while CS_n=0: shift register <= {MOSI, shreg[DATA_W-1:1]}; bitCnt++.
- SHIFT, posedge while bitCnt<DATA_W: MISO <= shreg[0].
- SHIFT, posedge with bitCnt==DATA_W (completion):
  - rxData <= shift register; rxValid=1; go to DONE.
  - Latency: rxValid rises on the posedge after the DATA_W-th sampling negedge.
- DONE: MISO holds its value. At the first posedge with CS_n=1, go to IDLE. A new word always requires CS_n to be deasserted between transfers.
- Abort: CS_n sampled high on a posedge in SHIFT with bitCnt<DATA_W:
  - Go to IDLE, bitCnt=0.
  - Partial word is discarded; rxData and rxValid are unchanged.
  - TX word already moved into the shift register is lost.
- Negedge activity with CS_n=1 is ignored.
- rxAck (posedge): clears rxValid. rxAck with rxValid=0 has no effect.
- Simultaneous rxAck and completion on the same posedge: rxValid stays 1 with the new data, and overrun is NOT set.
- Completion while rxValid=1 and no rxAck on that edge: rxData is overwritten and overrun is set to 1. overrun is cleared only by reset.
- busy = (state != IDLE).
- Reset asserted mid-transfer: all reset values apply immediately; no partial rxValid is produced.

Optional Feature:
- Macro: SPI_SLAVE_TRISTATE_EN
- Defined: MISO is 1'bz whenever CS_n=1, so multiple slaves can share one MISO wire. With CS_n=0, MISO follows the registered value described above.
- Undefined: MISO is always the registered value, which is 0 after reset. Slave MISO lines are muxed externally.

Test Plan:
- Normal transfer. Reset; txLoad with 8'hA5; CS_n low; master drives MOSI with 8'h3C LSB first.
  - MISO at successive sampling negedges reads 1,0,1,0,0,1,0,1.
  - rxData=8'h3C and rxValid=1 one posedge after the 8th negedge.
  - txReady=1 from the first shift posedge onward.
- No TX word loaded. Transfer MOSI 8'hFF with no txLoad → MISO is 0 for all 8 bits; rxData=8'hFF.
- Overrun. Two back-to-back words 8'h12 then 8'h34, with CS_n high between them and no rxAck → rxData=8'h34, rxValid=1, overrun=1. Repeat with rxAck asserted on the second completion edge → overrun=0.
- Abort. Raise CS_n after 4 bits of 8'hF0 → rxValid=0, busy=0. A following full transfer of 8'h5A gives rxData=8'h5A.
- Ignored load. txLoad 8'h11, then txLoad 8'h22 while txReady=0; transfer → MISO sends 8'h11.
- Reset mid-transfer. Assert reset after 3 bits → all outputs return to reset values asynchronously. A following transfer of 8'hC3 is received correctly.
